// File: rtl/pkt_desc_dispatch.sv
// -----------------------------------------------------------------------------
// pkt_desc_dispatch
//
// Pops packet descriptors from the upstream descriptor prefetch ring buffer.
// Each descriptor is split into a stream of FLIT_BYTES-sized read requests
// for the DMA read engine.
//
// Descriptor layout (DESC_WIDTH bits, LSB first):
//   [ADDR_WIDTH-1:0] host address, then LEN_WIDTH bits byte length,
//   then QID_WIDTH bits queue id.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   rb_rd_data    ring buffer head descriptor
//   rb_rd_en      pop head descriptor
//   rb_occup      ring buffer occupancy (already net of this cycle's pop)
//   enable        allow new descriptor pops (an active descriptor always completes)
//   req_valid/req_ready  flit request handshake
//   req_addr      flit host address
//   req_bytes     valid bytes in this flit (1..FLIT_BYTES)
//   req_qid       queue id of the owning descriptor
//   req_last      last flit of the descriptor
//   desc_cnt      descriptors popped (including zero-length ones)
//   flit_cnt      request handshakes completed
//   zero_len_cnt  zero-length descriptors dropped (saturating)
//
// Optional feature macro: PKT_DESC_DISPATCH_BACK2BACK_EN
//   When defined, the next descriptor is popped in the same cycle as the
//   last-flit handshake. This gives gap-free request streams. rb_rd_en then
//   also depends on req_ready.
// -----------------------------------------------------------------------------
module pkt_desc_dispatch #(
    parameter int RB_AWIDTH  = 9,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int QID_WIDTH  = 16,
    parameter int DESC_WIDTH = ADDR_WIDTH + LEN_WIDTH + QID_WIDTH,
    parameter int FLIT_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DESC_WIDTH-1:0]         rb_rd_data,
    output logic                          rb_rd_en,
    input  logic [RB_AWIDTH-1:0]          rb_occup,
    input  logic                          enable,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [$clog2(FLIT_BYTES):0]   req_bytes,
    output logic [QID_WIDTH-1:0]          req_qid,
    output logic                          req_last,
    output logic [31:0]                   desc_cnt,
    output logic [31:0]                   flit_cnt,
    output logic [15:0]                   zero_len_cnt
);

    localparam int BW = $clog2(FLIT_BYTES) + 1;
    localparam logic [LEN_WIDTH-1:0]  FLIT_LEN  = LEN_WIDTH'(FLIT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] FLIT_STEP = ADDR_WIDTH'(FLIT_BYTES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_enable;
    logic [RB_AWIDTH-1:0]    r_occ;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_rem;
    logic [QID_WIDTH-1:0]    r_qid;
    logic [31:0]             r_desc_cnt;
    logic [31:0]             r_flit_cnt;
    logic [15:0]             r_zero_cnt;

    logic [ADDR_WIDTH-1:0]   w_desc_addr;
    logic [LEN_WIDTH-1:0]    w_desc_len;
    logic [QID_WIDTH-1:0]    w_desc_qid;
    logic                    w_last;
    logic                    w_hs;
    logic                    w_can_pop;
    logic                    w_pop;

    assign w_desc_addr = rb_rd_data[ADDR_WIDTH-1:0];
    assign w_desc_len  = rb_rd_data[ADDR_WIDTH +: LEN_WIDTH];
    assign w_desc_qid  = rb_rd_data[ADDR_WIDTH+LEN_WIDTH +: QID_WIDTH];

    assign w_last = (r_rem <= FLIT_LEN);
    assign w_hs   = (r_state == S_ISSUE) && req_ready;

    // r_occ is rb_occup from the previous cycle. rb_occup is already reduced
    // by any pop in that cycle, so r_occ never overcounts. The pop decision
    // uses only registered state; it must never look at rb_occup, because
    // rb_occup depends combinationally on rb_rd_en. rst_n gates the pop so
    // that no descriptor is lost while reset is being applied.
    assign w_can_pop = r_enable && (r_occ != '0);

`ifdef PKT_DESC_DISPATCH_BACK2BACK_EN
    assign w_pop = rst_n && w_can_pop &&
                   ((r_state == S_IDLE) || (w_hs && w_last));
`else
    assign w_pop = rst_n && w_can_pop && (r_state == S_IDLE);
`endif

    assign rb_rd_en     = w_pop;
    assign req_valid    = (r_state == S_ISSUE);
    assign req_addr     = r_addr;
    assign req_qid      = r_qid;
    assign req_last     = w_last && (r_state == S_ISSUE);
    // On the last flit r_rem is at most FLIT_BYTES, so it fits in BW bits.
    assign req_bytes    = (r_state != S_ISSUE) ? '0 :
                          (w_last ? r_rem[BW-1:0] : BW'(FLIT_BYTES));
    assign desc_cnt     = r_desc_cnt;
    assign flit_cnt     = r_flit_cnt;
    assign zero_len_cnt = r_zero_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_enable   <= 1'b0;
            r_occ      <= '0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_qid      <= '0;
            r_desc_cnt <= '0;
            r_flit_cnt <= '0;
            r_zero_cnt <= '0;
        end else begin
            r_enable <= enable;
            r_occ    <= rb_occup;

            if (w_hs) begin
                r_flit_cnt <= r_flit_cnt + 32'd1;
                r_addr     <= r_addr + FLIT_STEP;
                r_rem      <= r_rem - FLIT_LEN;
                if (w_last) begin
                    r_state <= S_IDLE;
                end
            end

            // A pop overrides the handshake updates above. With back-to-back
            // enabled, a pop can land in the same cycle as the last handshake.
            if (w_pop) begin
                r_desc_cnt <= r_desc_cnt + 32'd1;
                if (w_desc_len == '0) begin
                    if (r_zero_cnt != 16'hFFFF) begin
                        r_zero_cnt <= r_zero_cnt + 16'd1;
                    end
                    r_state <= S_IDLE;
                end else begin
                    r_addr  <= w_desc_addr;
                    r_rem   <= w_desc_len;
                    r_qid   <= w_desc_qid;
                    r_state <= S_ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_desc_dispatch.sv
module tb_pkt_desc_dispatch;

    localparam int RB_AW = 9;
    localparam int AW    = 64;
    localparam int LW    = 16;
    localparam int QW    = 16;
    localparam int DW    = AW + LW + QW;
    localparam int FB    = 64;
    localparam int BW    = $clog2(FB) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  rb_rd_data;
    logic           rb_rd_en;
    logic [RB_AW-1:0] rb_occup;
    logic           enable = 1'b0;
    logic           req_valid;
    logic           req_ready = 1'b0;
    logic [AW-1:0]  req_addr;
    logic [BW-1:0]  req_bytes;
    logic [QW-1:0]  req_qid;
    logic           req_last;
    logic [31:0]    desc_cnt;
    logic [31:0]    flit_cnt;
    logic [15:0]    zero_len_cnt;

    always #5 clk = ~clk;

    pkt_desc_dispatch #(
        .RB_AWIDTH(RB_AW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .QID_WIDTH(QW), .DESC_WIDTH(DW), .FLIT_BYTES(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rb_rd_data(rb_rd_data), .rb_rd_en(rb_rd_en), .rb_occup(rb_occup),
        .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_bytes(req_bytes), .req_qid(req_qid),
        .req_last(req_last),
        .desc_cnt(desc_cnt), .flit_cnt(flit_cnt), .zero_len_cnt(zero_len_cnt)
    );

    // ---------------- ring buffer model ----------------
    logic [DW-1:0] rb_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rb_cnt;
    assign rb_cnt     = wr_ptr - rd_ptr;
    assign rb_rd_data = rb_mem[rd_ptr[9:0]];
    assign rb_occup   = RB_AW'(rb_cnt - int'(rb_rd_en));

    always @(posedge clk) begin
        if (rb_rd_en && rb_cnt > 0) rd_ptr <= rd_ptr + 1;
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] bytes;
        logic [QW-1:0] qid;
        logic          last;
    } flit_t;

    flit_t exp_q[$];
    int    vq[$];
    int    n_desc = 0, n_flit = 0, n_zero = 0;
    int    hs_cnt = 0;
    int    cyc = 0;
    int    checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    // Expected flits come straight from the length arithmetic: the descriptor
    // is cut into FLIT_BYTES chunks, and the final chunk carries the remainder.
    task automatic push_desc(input logic [AW-1:0] a, input int len, input logic [QW-1:0] q);
        flit_t f;
        rb_mem[wr_ptr[9:0]] = {q, LW'(len), a};
        wr_ptr = wr_ptr + 1;
        n_desc++;
        if (len == 0) n_zero++;
        for (int off = 0; off < len; off += FB) begin
            f.addr  = a + AW'(off);
            f.bytes = BW'((len - off) < FB ? (len - off) : FB);
            f.qid   = q;
            f.last  = (len - off) <= FB;
            exp_q.push_back(f);
            n_flit++;
        end
    endtask

    // ---------------- monitor ----------------
    logic          stalled = 1'b0;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_bytes;
    logic [QW-1:0] s_qid;
    logic          s_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (rb_rd_en) chk("pop_nonempty", 64'(rb_cnt != 0), 64'd1);
            if (stalled) begin
                chk("hold_valid", 64'(req_valid), 64'd1);
                chk("hold_addr", req_addr, s_addr);
                chk("hold_bytes", 64'(req_bytes), 64'(s_bytes));
                chk("hold_qid", 64'(req_qid), 64'(s_qid));
                chk("hold_last", 64'(req_last), 64'(s_last));
            end
            if (req_valid) vq.push_back(cyc);
            if (req_valid && req_ready) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit actual addr=%0h expected none", req_addr);
                end else begin
                    flit_t e;
                    e = exp_q.pop_front();
                    chk("flit_addr", req_addr, e.addr);
                    chk("flit_bytes", 64'(req_bytes), 64'(e.bytes));
                    chk("flit_qid", 64'(req_qid), 64'(e.qid));
                    chk("flit_last", 64'(req_last), 64'(e.last));
                end
            end
            stalled = req_valid && !req_ready;
            s_addr  = req_addr;
            s_bytes = req_bytes;
            s_qid   = req_qid;
            s_last  = req_last;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_check(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && rb_cnt == 0 && !req_valid) done = 1;
        end
        tick();
        tick();
        chk({tag, "_drain"}, 64'(done), 64'd1);
        chk({tag, "_desc_cnt"}, 64'(desc_cnt), 64'(n_desc));
        chk({tag, "_flit_cnt"}, 64'(flit_cnt), 64'(n_flit));
        chk({tag, "_zero_cnt"}, 64'(zero_len_cnt), 64'(n_zero));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int want_span;
        bit seen;

        // Reset, with a descriptor already waiting in the ring.
        enable    = 1'b1;
        req_ready = 1'b1;
        rst_n     = 1'b0;
        push_desc(64'h1000, 200, 16'd3);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_rd_en", 64'(rb_rd_en), 64'd0);
        chk("rst_desc_cnt", 64'(desc_cnt), 64'd0);
        chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("rst_zero_cnt", 64'(zero_len_cnt), 64'd0);
        chk("rst_addr", req_addr, 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rd_en", 64'(rb_rd_en), 64'd0);
        drain_and_check("basic", 50);

        // Backpressure on the first flit.
        req_ready = 1'b0;
        push_desc(64'hDEAD_BEEF_0000_0040, 128, 16'h55);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (req_valid) seen = 1;
        end
        chk("bp_valid_seen", 64'(seen), 64'd1);
        repeat (5) tick();
        req_ready = 1'b1;
        drain_and_check("bp", 50);

        // Zero-length descriptor followed by a single-flit one.
        push_desc(64'h9999, 0, 16'd1);
        push_desc(64'h2000, 64, 16'd2);
        drain_and_check("zero", 50);

        // Trickle: one descriptor every 10 cycles.
        for (int k = 0; k < 6; k++) begin
            push_desc({$urandom, $urandom}, int'($urandom_range(0, 150)), QW'($urandom));
            repeat (10) tick();
        end
        drain_and_check("trickle", 100);

        // Back-to-back: three single-flit descriptors are preloaded.
        enable = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) push_desc(64'h5000 + 64'(k * 64), 64, QW'(k));
        repeat (3) tick();
        vq.delete();
        enable = 1'b1;
        drain_and_check("b2b", 50);
`ifdef PKT_DESC_DISPATCH_BACK2BACK_EN
        want_span = 2;
`else
        // Each descriptor costs one flit cycle plus one idle cycle.
        want_span = 4;
`endif
        chk("b2b_valid_count", 64'(vq.size()), 64'd3);
        if (vq.size() >= 3) chk("b2b_span", 64'(vq[2] - vq[0]), 64'(want_span));

        // Randomized traffic with random backpressure and enable toggling.
        for (int c = 0, n = 0; c < 800; c++) begin
            req_ready = ($urandom % 10) < 7;
            enable    = ($urandom % 8) != 0;
            if (n < 40 && ($urandom % 6) == 0) begin
                logic [AW-1:0] a;
                int len;
                a = {$urandom, $urandom};
                if (($urandom % 5) == 0) a = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
                len = (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 300));
                push_desc(a, len, QW'($urandom));
                n++;
            end
            tick();
        end
        req_ready = 1'b1;
        enable    = 1'b1;
        drain_and_check("random", 3000);

        // Reset in the middle of a four-flit descriptor.
        push_desc(64'h3000, 256, 16'd7);
        base = hs_cnt;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            if (hs_cnt > base) seen = 1;
        end
        chk("mid_first_hs", 64'(seen), 64'd1);
        #1;
        req_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        n_desc = 0;
        n_flit = 0;
        n_zero = 0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_rd_en", 64'(rb_rd_en), 64'd0);
        chk("mid_rst_desc_cnt", 64'(desc_cnt), 64'd0);
        chk("mid_rst_flit_cnt", 64'(flit_cnt), 64'd0);
        tick();
        req_ready = 1'b1;
        push_desc(64'h4000, 100, 16'd9);
        drain_and_check("after_rst", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
